// File: rtl/axil_regbank_slave_pkg.sv
// Shared response codes, channel state encodings and address decode helper
// for the AXI4-Lite register bank.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/axil_regbank_slave_strb_merge.sv
// Byte-lane merge: each lane takes the new write byte when its strobe is set,
// otherwise keeps the old register byte.
module axil_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // select each byte lane from old or new data
  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wstrb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
      else          merged[b*8 +: 8] = old_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axil_regbank_slave.sv
// AXI4-Lite slave register bank with independent write/read channel FSMs.
// Optional ID register at index NUM_REGS when AXIL_REGBANK_ID_EN is defined.
module axil_regbank_slave
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
`ifdef AXIL_REGBANK_ID_EN
  , parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'hA5A1_0001)
`endif
) (
  input  logic                           s3_axi_aclk,
  input  logic                           s3_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s3_axi_awaddr,
  input  logic                           s3_axi_awvalid,
  output logic                           s3_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s3_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s3_axi_wstrb,
  input  logic                           s3_axi_wvalid,
  output logic                           s3_axi_wready,
  output logic [RESP_WIDTH-1:0]          s3_axi_bresp,
  output logic                           s3_axi_bvalid,
  input  logic                           s3_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s3_axi_araddr,
  input  logic                           s3_axi_arvalid,
  output logic                           s3_axi_arready,
  output logic [DATA_WIDTH-1:0]          s3_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s3_axi_rresp,
  output logic                           s3_axi_rvalid,
  input  logic                           s3_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int          STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int          IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] NREGS    = 32'(NUM_REGS);
`ifdef AXIL_REGBANK_ID_EN
  localparam logic [31:0] LIMIT    = NREGS + 32'd1;
`else
  localparam logic [31:0] LIMIT    = NREGS;
`endif

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  w_state_t              w_state_r;
  r_state_t              r_state_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]     wstrb_r;
  logic                  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [RESP_WIDTH-1:0] bresp_r, rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [NUM_REGS-1:0]   wr_pulse_r;

  logic                  aw_fire_s, w_fire_s, ar_fire_s, commit_s;
  logic [ADDR_WIDTH-1:0] w_addr_s;
  logic [DATA_WIDTH-1:0] w_data_s, w_merged_s, r_data_s;
  logic [STRB_W-1:0]     w_strb_s;
  logic [31:0]           w_idx_s, r_idx_s;
  logic                  w_in_range_s, r_in_range_s;
  logic [IW-1:0]         w_sel_s, r_sel_s;
  logic [NUM_REGS-1:0]   w_onehot_s;
  logic [1:0]            w_code_s, r_code_s;

  assign aw_fire_s = s3_axi_awvalid && awready_r;
  assign w_fire_s  = s3_axi_wvalid && wready_r;
  assign ar_fire_s = s3_axi_arvalid && arready_r;

  // pick the write address/data from the buffered copy when it arrived earlier
  always_comb begin
    if (w_state_r == W_HAVE_A) w_addr_s = awaddr_r;
    else                       w_addr_s = s3_axi_awaddr;
    if (w_state_r == W_HAVE_D) begin
      w_data_s = wdata_r;
      w_strb_s = wstrb_r;
    end else begin
      w_data_s = s3_axi_wdata;
      w_strb_s = s3_axi_wstrb;
    end
  end

  assign w_idx_s      = addr_to_idx(32'(w_addr_s), ADDR_LSB);
  assign w_in_range_s = (w_idx_s < NREGS);
  assign w_sel_s      = w_in_range_s ? w_idx_s[IW-1:0] : '0;

  axil_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_data (regs_r[w_sel_s]),
    .wdata    (w_data_s),
    .wstrb    (w_strb_s),
    .merged   (w_merged_s)
  );

  // a commit happens on the edge where the second half of the AW/W pair lands
  always_comb begin
    case (w_state_r)
      W_IDLE:   commit_s = aw_fire_s && w_fire_s;
      W_HAVE_A: commit_s = w_fire_s;
      W_HAVE_D: commit_s = aw_fire_s;
      default:  commit_s = 1'b0;
    endcase
  end

  // write response code and per-register decode
  always_comb begin
    w_code_s   = RESP_OKAY;
    w_onehot_s = '0;
    if (!w_in_range_s) begin
      if (w_idx_s < LIMIT) w_code_s = RESP_SLVERR;
      else                 w_code_s = RESP_DECERR;
    end else begin
      w_onehot_s[w_sel_s] = 1'b1;
      if (RO_MASK[w_sel_s]) w_code_s = RESP_SLVERR;
      else                  w_code_s = RESP_OKAY;
    end
  end

  // register storage: RO entries mirror hw_in, RW entries take committed merges
  always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
    if (!s3_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i])                      regs_r[i] <= hw_in[i*DATA_WIDTH +: DATA_WIDTH];
        else if (commit_s && w_onehot_s[i])  regs_r[i] <= w_merged_s;
      end
    end
  end

  // write channel FSM with registered handshake outputs
  always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
    if (!s3_axi_aresetn) begin
      w_state_r  <= W_IDLE;
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      bvalid_r   <= 1'b0;
      bresp_r    <= '0;
      awaddr_r   <= '0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
      wr_pulse_r <= '0;
    end else begin
      wr_pulse_r <= '0;
      if (commit_s) begin
        w_state_r  <= W_RESP;
        awready_r  <= 1'b0;
        wready_r   <= 1'b0;
        bvalid_r   <= 1'b1;
        bresp_r    <= RESP_WIDTH'(w_code_s);
        wr_pulse_r <= w_onehot_s;
      end else begin
        case (w_state_r)
          W_IDLE: begin
            if (aw_fire_s) begin
              awaddr_r  <= s3_axi_awaddr;
              awready_r <= 1'b0;
              w_state_r <= W_HAVE_A;
            end else if (w_fire_s) begin
              wdata_r   <= s3_axi_wdata;
              wstrb_r   <= s3_axi_wstrb;
              wready_r  <= 1'b0;
              w_state_r <= W_HAVE_D;
            end
          end
          W_HAVE_A, W_HAVE_D: w_state_r <= w_state_r;
          W_RESP: begin
            if (s3_axi_bready) begin
              bvalid_r  <= 1'b0;
              awready_r <= 1'b1;
              wready_r  <= 1'b1;
              w_state_r <= W_IDLE;
            end
          end
          default: begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign r_idx_s      = addr_to_idx(32'(s3_axi_araddr), ADDR_LSB);
  assign r_in_range_s = (r_idx_s < NREGS);
  assign r_sel_s      = r_in_range_s ? r_idx_s[IW-1:0] : '0;

  // read data/response for the presented read address
  always_comb begin
    r_data_s = '0;
    r_code_s = RESP_DECERR;
    if (r_in_range_s) begin
      r_code_s = RESP_OKAY;
      if (RO_MASK[r_sel_s]) r_data_s = hw_in[int'(r_sel_s)*DATA_WIDTH +: DATA_WIDTH];
      else                  r_data_s = regs_r[r_sel_s];
    end
`ifdef AXIL_REGBANK_ID_EN
    else if (r_idx_s == NREGS) begin
      r_data_s = ID_VALUE;
      r_code_s = RESP_OKAY;
    end
`endif
    else begin
      r_data_s = '0;
      r_code_s = RESP_DECERR;
    end
  end

  // read channel FSM; data captured at the AR handshake edge
  always_ff @(posedge s3_axi_aclk or negedge s3_axi_aresetn) begin
    if (!s3_axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= '0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_fire_s) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= r_data_s;
            rresp_r   <= RESP_WIDTH'(r_code_s);
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (s3_axi_rready) begin
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
            r_state_r <= R_IDLE;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
  end

  assign s3_axi_awready = awready_r;
  assign s3_axi_wready  = wready_r;
  assign s3_axi_bvalid  = bvalid_r;
  assign s3_axi_bresp   = bresp_r;
  assign s3_axi_arready = arready_r;
  assign s3_axi_rvalid  = rvalid_r;
  assign s3_axi_rdata   = rdata_r;
  assign s3_axi_rresp   = rresp_r;
  assign wr_pulse       = wr_pulse_r;

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Self-checking bench for axil_regbank_slave: transaction-level model plus
// directed literal checks. Honours AXIL_REGBANK_ID_EN when defined.
module tb_axil_regbank_slave;

  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0008;
  localparam logic [31:0] ID_VAL = 32'hA5A1_0001;
`ifdef AXIL_REGBANK_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0]  awaddr = 8'd0, araddr = 8'd0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [2:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NR*32-1:0] hw_in, reg_out;
  logic [NR-1:0] wr_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axil_regbank_slave #(.RO_MASK(RO)) dut (
    .s3_axi_aclk(clk), .s3_axi_aresetn(rst_n),
    .s3_axi_awaddr(awaddr), .s3_axi_awvalid(awvalid), .s3_axi_awready(awready),
    .s3_axi_wdata(wdata), .s3_axi_wstrb(wstrb), .s3_axi_wvalid(wvalid), .s3_axi_wready(wready),
    .s3_axi_bresp(bresp), .s3_axi_bvalid(bvalid), .s3_axi_bready(bready),
    .s3_axi_araddr(araddr), .s3_axi_arvalid(arvalid), .s3_axi_arready(arready),
    .s3_axi_rdata(rdata), .s3_axi_rresp(rresp), .s3_axi_rvalid(rvalid), .s3_axi_rready(rready),
    .reg_out(reg_out), .hw_in(hw_in), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rego(input int i);
    return reg_out[i*32 +: 32];
  endfunction

  // transaction-level model: pending AW/W queues, expected B and R responses
  logic [31:0]   mregs [NR];
  logic [NR-1:0] exp_pulse;
  logic [1:0]    b_q [$];
  logic [33:0]   r_q [$];
  int            aw_q [$];
  logic [35:0]   w_q [$];
  logic [NR-1:0] np;
  int            midx, ma;
  logic [35:0]   mw;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NR; i++) mregs[i] = 32'd0;
        exp_pulse = '0;
        b_q.delete(); r_q.delete(); aw_q.delete(); w_q.delete();
      end else begin
        if (rvalid && rready && r_q.size() > 0) void'(r_q.pop_front());
        if (arvalid && arready) begin
          midx = int'(araddr) / 4;
          if (midx < NR) r_q.push_back({2'd0, RO[midx] ? hw_in[midx*32 +: 32] : mregs[midx]});
          else if (ID_EN && midx == NR) r_q.push_back({2'd0, ID_VAL});
          else r_q.push_back({2'd3, 32'd0});
        end
        if (bvalid && bready && b_q.size() > 0) void'(b_q.pop_front());
        if (awvalid && awready) aw_q.push_back(int'(awaddr));
        if (wvalid && wready) w_q.push_back({wstrb, wdata});
        np = '0;
        if (aw_q.size() > 0 && w_q.size() > 0) begin
          ma = aw_q.pop_front();
          mw = w_q.pop_front();
          midx = ma / 4;
          if (midx < NR) begin
            np[midx] = 1'b1;
            if (RO[midx]) b_q.push_back(2'd2);
            else begin
              for (int b = 0; b < 4; b++)
                if (mw[32+b]) mregs[midx][b*8 +: 8] = mw[b*8 +: 8];
              b_q.push_back(2'd0);
            end
          end else if (ID_EN && midx == NR) b_q.push_back(2'd2);
          else b_q.push_back(2'd3);
        end
        exp_pulse = np;
      end
    end
  end

  // every-cycle comparison of DUT outputs against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ready", {awready, wready, arready}, 3'b111);
        chk("rst_valid", {bvalid, rvalid}, 2'b00);
        chk("rst_resp_data", {bresp, rresp, rdata}, 38'd0);
        chk("rst_pulse", wr_pulse, 16'd0);
      end else begin
        for (int i = 0; i < NR; i++)
          if (!RO[i]) chk($sformatf("reg_out[%0d]", i), rego(i), mregs[i]);
        chk("wr_pulse", wr_pulse, exp_pulse);
        chk("bvalid", bvalid, b_q.size() != 0);
        if (b_q.size() != 0) chk("bresp", bresp, {1'b0, b_q[0]});
        chk("rvalid", rvalid, r_q.size() != 0);
        if (r_q.size() != 0) chk("rresp_rdata", {rresp, rdata}, {1'b0, r_q[0]});
      end
    end
  end

  task automatic do_awz(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk);
      ok = awready && wready;
    end
    chk("aw_w_handshake", ok, 1'b1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [7:0] a);
    bit ok = 1'b0;
    awaddr = a; awvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk);
      ok = awready;
    end
    chk("aw_handshake", ok, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk);
      ok = wready;
    end
    chk("w_handshake", ok, 1'b1);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [7:0] a);
    bit ok = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk);
      ok = arready;
    end
    chk("ar_handshake", ok, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
    bit seen = 1'b0;
    do_ar(a);
    for (int n = 0; n < 20 && !seen; n++) begin
      seen = rvalid;
      if (!seen) @(negedge clk);
    end
    chk("rvalid_wait", seen, 1'b1);
    d = rdata; r = rresp;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [31:0] d;
  logic [2:0]  r;

  initial begin : main
    for (int i = 0; i < NR; i++) hw_in[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    hw_in[3*32 +: 32] = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_readies", {awready, wready, arready}, 3'b111);
    chk("reset_reg0", rego(0), 32'd0);

    // AW and W together
    do_awz(8'h00, 32'd25, 4'hF);
    chk("t1_bvalid", bvalid, 1'b1);
    chk("t1_bresp", bresp, 3'd0);
    chk("t1_reg0", rego(0), 32'd25);
    chk("t1_pulse", wr_pulse, 16'h0001);
    @(negedge clk);
    chk("t1_pulse_clear", wr_pulse, 16'h0000);
    chk("t1_bdone", {bvalid, awready}, 2'b01);

    // W three cycles ahead of AW
    do_w(32'd34, 4'hF);
    chk("t2_wready_low", {wready, awready}, 2'b01);
    repeat (2) begin
      @(negedge clk);
      chk("t2_wait_wready", wready, 1'b0);
      chk("t2_no_commit", rego(1), 32'd0);
    end
    do_aw(8'h04);
    chk("t2_reg1", rego(1), 32'd34);
    chk("t2_bresp", {bvalid, bresp}, 4'b1000);
    chk("t2_pulse", wr_pulse, 16'h0002);
    @(negedge clk);

    // partial strobe merge
    do_awz(8'h08, 32'h1122_3344, 4'hF);
    @(negedge clk);
    do_awz(8'h08, 32'hAABB_CCDD, 4'h5);
    @(negedge clk);
    do_read(8'h08, d, r);
    chk("t3_rdata", d, 32'h11BB_33DD);
    chk("t3_rresp", r, 3'd0);

    // read-only register
    do_awz(8'h0C, 32'h1234_5678, 4'hF);
    chk("t4_bresp", bresp, 3'd2);
    chk("t4_pulse", wr_pulse, 16'h0008);
    @(negedge clk);
    chk("t4_reg3", rego(3), 32'hDEAD_BEEF);
    do_read(8'h0C, d, r);
    chk("t4_rdata", d, 32'hDEAD_BEEF);
    chk("t4_rresp", r, 3'd0);

    // index 16: out of range, or ID register when enabled
    do_read(8'h40, d, r);
    chk("t5_rdata", d, ID_EN ? ID_VAL : 32'd0);
    chk("t5_rresp", r, ID_EN ? 3'd0 : 3'd3);
    do_awz(8'h40, 32'h0000_FFFF, 4'hF);
    chk("t5_bresp", bresp, ID_EN ? 3'd2 : 3'd3);
    chk("t5_pulse", wr_pulse, 16'h0000);
    @(negedge clk);
    do_awz(8'h44, 32'h0000_FFFF, 4'hF);
    chk("t5_bresp_beyond", bresp, 3'd3);
    @(negedge clk);

    // B and R backpressure
    bready = 1'b0;
    do_awz(8'h10, 32'hCAFE_0005, 4'hF);
    repeat (5) begin
      @(negedge clk);
      chk("t6_bhold", {bvalid, bresp, awready, wready}, 6'b1_000_00);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("t6_bdone", bvalid, 1'b0);
    rready = 1'b0;
    do_ar(8'h10);
    repeat (5) begin
      @(negedge clk);
      chk("t6_rhold", {rvalid, arready, rdata}, {2'b10, 32'hCAFE_0005});
    end
    rready = 1'b1;
    @(negedge clk);
    chk("t6_rdone", rvalid, 1'b0);

    // read in the commit cycle of a write to the same register
    awaddr = 8'h18; wdata = 32'h0000_0077; wstrb = 4'hF; araddr = 8'h18;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t8_old_value", {rvalid, rdata}, {1'b1, 32'd0});
    chk("t8_reg6", rego(6), 32'h0000_0077);
    @(negedge clk);

    // reset while holding only the write address
    do_aw(8'h14);
    chk("t7_have_a", {awready, wready}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_ready", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    chk("t7_rst_regs", {rego(0), rego(1), rego(6)}, 96'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_w(32'h0000_0099, 4'hF);
    chk("t7_no_commit", {bvalid, rego(5)}, 33'd0);
    do_aw(8'h14);
    chk("t7_reg5", rego(5), 32'h0000_0099);
    @(negedge clk);

    // empty strobe still pulses but leaves contents alone
    do_awz(8'h14, 32'hFFFF_FFFF, 4'h0);
    chk("t9_bresp", bresp, 3'd0);
    chk("t9_pulse", wr_pulse, 16'h0020);
    chk("t9_reg5", rego(5), 32'h0000_0099);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_regbank_slave.md
Name: axil_regbank_slave

Overview:
- Parametrised AXI4-Lite slave register bank: NUM_REGS registers of DATA_WIDTH bits, each either read/write from the bus or read-only and hardware-fed.
- Write and read channels run independent FSMs; AW and W are accepted in any order.
- Byte strobes are honoured; OKAY/SLVERR/DECERR responses are returned.
- Sits behind the interconnect as the control/status block for user logic.

Parameters:
- DATA_WIDTH, 32, bus data width; multiple of 8, 32 or 64.
- ADDR_WIDTH, 8, byte address width.
- RESP_WIDTH, 3, response width; bits [1:0] carry the AXI code, upper bits are always 0.
- NUM_REGS, 16, register count; at most 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (value = hw_in slice i).
- RESET_VAL, 0, reset value applied to every R/W register.

Ports:
- s3_axi_aclk  in  1  clock
- s3_axi_aresetn  in  1  asynchronous active-low reset
- s3_axi_awaddr  in  ADDR_WIDTH  write address
- s3_axi_awvalid / s3_axi_awready  in / out  1  AW handshake
- s3_axi_wdata  in  DATA_WIDTH  write data
- s3_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s3_axi_wvalid / s3_axi_wready  in / out  1  W handshake
- s3_axi_bresp  out  RESP_WIDTH  write response
- s3_axi_bvalid / s3_axi_bready  out / in  1  B handshake
- s3_axi_araddr  in  ADDR_WIDTH  read address
- s3_axi_arvalid / s3_axi_arready  in / out  1  AR handshake
- s3_axi_rdata  out  DATA_WIDTH  read data
- s3_axi_rresp  out  RESP_WIDTH  read response
- s3_axi_rvalid / s3_axi_rready  out / in  1  R handshake
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i is at slice i
- hw_in  in  NUM_REGS*DATA_WIDTH  hardware values for RO registers; slices for RW registers are ignored
- wr_pulse  out  NUM_REGS  one-cycle strobe marking a committed write to register i

Behaviour:
- Reset (async assert, sync release):
  - awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; wr_pulse=0.
  - All RW registers are set to RESET_VAL.
  - Reset mid-transaction abandons the transaction; no partial write is committed.
- Register index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored (no misalignment error).
- Write FSM states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP:
  - W_IDLE: AW and W in the same cycle -> W_RESP. AW only -> W_HAVE_A (awready=0). W only -> W_HAVE_D (wready=0).
  - W_HAVE_A: on W handshake -> W_RESP. W_HAVE_D: on AW handshake -> W_RESP.
  - Commit occurs on the edge entering W_RESP: for each byte b with wstrb[b]=1, the register takes wdata byte b.
  - bvalid=1 and wr_pulse[i]=1 in the first W_RESP cycle; wr_pulse is held for that one cycle only.
  - W_RESP: awready=wready=0; stays until bready; on B handshake -> W_IDLE with both readies=1.
  - No new AW or W is accepted while in W_RESP.
- Write response codes:
  - index >= NUM_REGS -> DECERR (3), no commit, no pulse.
  - RO register -> SLVERR (2), no commit, but wr_pulse still fires.
  - otherwise OKAY (0).
  - wstrb=0 -> OKAY with contents unchanged and wr_pulse fired.
- Read FSM states R_IDLE, R_DATA:
  - R_IDLE, arready=1. AR handshake -> R_DATA with rdata/rresp registered; latency is one cycle from handshake to rvalid.
  - RW register: rdata = stored value. RO register: rdata = hw_in sampled at the handshake edge.
  - Out of range: rdata=0, rresp=DECERR.
  - R_DATA: arready=0; rdata/rresp held stable until rready; on R handshake -> R_IDLE.
- Simultaneous events:
  - A read AR handshake in the same cycle as a write commit to the same register returns the pre-write value.
  - Read and write paths never stall each other.
- Valids never depend combinationally on ready inputs.

Optional Feature:
- Macro: AXIL_REGBANK_ID_EN.
- Defined: adds parameter ID_VALUE (default 32'hA5A1_0001). Index NUM_REGS reads as ID_VALUE with OKAY. Writes to index NUM_REGS return SLVERR. The DECERR threshold moves to index > NUM_REGS.
- Undefined: index NUM_REGS is out of range and returns DECERR for both read and write.

Decomposition:
- Package axil_pkg holds:
  - response constants RESP_OKAY=0, RESP_SLVERR=2, RESP_DECERR=3;
  - write/read state enums;
  - function addr_to_idx.
- One sub-module, axil_strb_merge: combinational byte-lane merge of old data, wdata and wstrb, parametrised by DATA_WIDTH. It is instantiated once, for the addressed register.

Test Plan:
- AW and W same cycle: addr 0x00, data 25, strb 0xF -> bvalid next cycle, bresp 0, reg_out[0]=25, wr_pulse[0] one cycle.
- W three cycles before AW: addr 0x04, data 34 -> wready low after W handshake; commit to reg 1 only after AW; bresp 0.
- Partial strobe: reg 2 holds 0x11223344; write 0xAABBCCDD with strb 0x5 -> reads back 0x11BB33DD.
- RO_MASK bit 3=1, hw_in slice 3 = 0xDEADBEEF: write addr 0x0C -> SLVERR and value unchanged; read addr 0x0C -> rdata 0xDEADBEEF, rresp 0.
- Read addr 0x40 (index 16) -> rdata 0, rresp 3. Write to the same address -> bresp 3, no pulse. Repeat with AXIL_REGBANK_ID_EN defined -> read returns ID_VALUE, rresp 0.
- Backpressure and reset:
  - hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=0;
  - hold rready=0 for 5 cycles -> rdata stable;
  - assert aresetn low while in W_HAVE_A -> no commit, all outputs at reset values.
